adder_sequencer: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit built on one shared SLICE-bit ripple-carry adder slice.
- Splits each operation into WIDTH/SLICE passes, least-significant slice first, with the carry registered between passes.
- Valid/ready handshake on both sides.
- Sits between the ALU issue logic and the writeback path wherever a full-width adder is too large or too slow for one cycle.

---
 rtl/adder_sequencer_pkg.sv | 19 +
 rtl/adder_slice.sv | 29 ++
 rtl/adder_sequencer.sv | 162 ++++++++++++++++
 tb/tb_adder_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sequencer_pkg.sv
// Shared types and constants for the multi-pass adder sequencer.
// Holds the FSM state enum, default geometry and the slice-index width helper.
package adder_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 16;

    // A single-pass build still needs a 1-bit index register.
    function automatic int idxClog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// SLICE-bit combinational ripple-carry adder shared by every pass of the sequencer.
// Reports the carry out of the top bit and signed overflow of the slice.
module adder_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [SLICE:0] carryChain;

    always_comb begin
        carryChain    = '0;
        carryChain[0] = cin;
        sum           = '0;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]          = a[i] ^ b[i] ^ carryChain[i];
            carryChain[i+1] = (a[i] & b[i]) | (carryChain[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = carryChain[SLICE];
    assign overflow = carryChain[SLICE] ^ carryChain[SLICE-1];

endmodule

// File: rtl/adder_sequencer.sv
// WIDTH-bit add/subtract built from WIDTH/SLICE passes over one shared adder slice.
// Define ADDSEQ_BACK_TO_BACK_EN to accept a new operation in the same cycle a result retires.
module adder_sequencer
    import adder_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = idxClog2(N);

    state_e            state_q,  state_d;
    logic [IW-1:0]     idx_q,    idx_d;
    logic              carry_q,  carry_d;
    logic [WIDTH-1:0]  opA_q,    opA_d;
    logic [WIDTH-1:0]  opB_q,    opB_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q,   cout_d;
    logic              ovf_q,    ovf_d;

    logic [SLICE-1:0]  sliceA;
    logic [SLICE-1:0]  sliceB;
    logic [SLICE-1:0]  sliceSum;
    logic              sliceCout;
    logic              sliceOvf;
    logic              accept;

    always_comb begin
        sliceA = '0;
        sliceB = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                sliceA = opA_q[i*SLICE +: SLICE];
                sliceB = opB_q[i*SLICE +: SLICE];
            end
        end
    end

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a        (sliceA),
        .b        (sliceB),
        .cin      (carry_q),
        .sum      (sliceSum),
        .cout     (sliceCout),
        .overflow (sliceOvf)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opA_q    <= '0;
            opB_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign accept = in_valid && in_ready;

    // Subtraction is folded into the operands at capture: b is inverted and the +1 rides in as carry-in.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opA_d   = op_a;
                    opB_d   = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[i*SLICE +: SLICE] = sliceSum;
                    end
                end
                carry_d = sliceCout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    cout_d  = sliceCout;
                    ovf_d   = sliceOvf;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (accept) begin
                        opA_d   = op_a;
                        opB_d   = sub ? ~op_b : op_b;
                        carry_d = sub;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
`ifdef ADDSEQ_BACK_TO_BACK_EN
                in_ready  = out_ready;
`else
                in_ready  = 1'b0;
`endif
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer: directed corner cases, backpressure, mid-op reset, random traffic.
// Expected gap between retire and next accept depends on ADDSEQ_BACK_TO_BACK_EN.
module tb_adder_sequencer;

    localparam int W = 32;
    localparam int S = 16;
    localparam int N = W / S;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           cycle = 0;
    int           readyMode = 0;
    int           retireCycle = 0;
    logic         prevValid = 1'b0;
    logic         prevReady = 1'b0;
    logic [W-1:0] prevResult = '0;
    logic         prevCout = 1'b0;
    logic         prevOvf = 1'b0;

    adder_sequencer #(.WIDTH(W), .SLICE(S)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Reference: plain integer arithmetic on the true values, not the slice datapath.
    function automatic exp_t modelOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint ua, ub, ur, sa, sb, sr, maxS, minS;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxS = (longint'(1) <<< (W - 1)) - 1;
        minS = -(longint'(1) <<< (W - 1));
        ur   = s ? (ua - ub) : (ua + ub);
        sr   = s ? (sa - sb) : (sa + sb);
        e.res = ur[W-1:0];
        e.c   = s ? (ua >= ub) : (ur >= (longint'(1) <<< W));
        e.v   = (sr > maxS) || (sr < minS);
        e.acc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout expected=event at cycle %0d", name, cycle);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output int accCycle);
        exp_t e;
        int   waited;
        @(posedge clock);
        #1;
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        waited   = 0;
        accCycle = -1;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            reportTimeout("accept_wait");
            in_valid = 1'b0;
        end else begin
            e     = modelOp(a, b, s);
            e.acc = cycle + 1;
            accCycle = e.acc;
            q.push_back(e);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            op_a     = $urandom;
            op_b     = $urandom;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) reportTimeout("drain_wait");
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: latency on each rising out_valid, stability while stalled, scoreboard pop on handshake.
    always @(negedge clock) begin
        if (!reset_n) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prevValid) begin
                    if (q.size() == 0) begin
                        reportTimeout("unexpected_out_valid");
                    end else begin
                        checkOutput("latency", 64'(cycle - q[0].acc), 64'(N));
                    end
                end else if (!prevReady) begin
                    checkOutput("held_result", 64'(result), 64'(prevResult));
                    checkOutput("held_cout", 64'(cout), 64'(prevCout));
                    checkOutput("held_overflow", 64'(overflow), 64'(prevOvf));
                end
                if (!out_ready) checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
                if (out_ready && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    checkOutput("result", 64'(result), 64'(e.res));
                    checkOutput("cout", 64'(cout), 64'(e.c));
                    checkOutput("overflow", 64'(overflow), 64'(e.v));
                    retireCycle = cycle + 1;
                end
            end
            prevValid  = out_valid;
            prevReady  = out_ready;
            prevResult = result;
            prevCout   = cout;
            prevOvf    = overflow;
        end
    end

    initial begin
        int acc;
        int acc2;
        int n;
        int expGap;
        logic [W-1:0] ra, rb;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        sub      = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_result", 64'(result), 64'(0));
        checkOutput("reset_cout", 64'(cout), 64'(0));
        checkOutput("reset_overflow", 64'(overflow), 64'(0));
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        $display("[TB] directed corner cases");
        applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, acc);
        applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, acc);
        applyStimulus(32'h00000000, 32'h00000001, 1'b1, acc);
        applyStimulus(32'h80000000, 32'h00000001, 1'b1, acc);
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, acc);
        applyStimulus(32'h12345678, 32'h00000000, 1'b1, acc);
        waitDrain();

        $display("[TB] backpressure");
        readyMode = 1;
        applyStimulus(32'hDEADBEEF, 32'h01010101, 1'b0, acc);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) reportTimeout("bp_out_valid");
        fork
            applyStimulus(32'h00000005, 32'h00000009, 1'b1, acc2);
            begin
                repeat (5) @(negedge clock) checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
                readyMode = 0;
            end
        join
`ifdef ADDSEQ_BACK_TO_BACK_EN
        expGap = 0;
`else
        expGap = 1;
`endif
        checkOutput("bp_accept_gap", 64'(acc2 - retireCycle), 64'(expGap));
        waitDrain();

        $display("[TB] reset mid-operation");
        applyStimulus(32'h12345678, 32'h11111111, 1'b0, acc);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midreset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("midreset_result", 64'(result), 64'(0));
        q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        applyStimulus(32'd3, 32'd4, 1'b0, acc);
        waitDrain();

        $display("[TB] random traffic");
        readyMode = 2;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 1) ra = 32'h7FFFFFFF;
            if (i % 8 == 3) rb = 32'h80000000;
            if (i % 8 == 5) rb = ra;
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), acc);
        end
        readyMode = 0;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
